plat_collision_scan: RTL and testbench

Sequential landing detector that consumes the per-block platform layout buses (x, y, length per platform) and decides whether the character lands on a platform during the current physics tick. It sits between the block generator (producer of the layout) and the character physics FSM. On each `start` request it snapshots the layout and character state, scans one platform per cycle, and returns the highest crossed platform top with a one-cycle `done` pulse.

---
 rtl/plat_collision_scan_if.sv | 36 +++
 rtl/plat_collision_scan.sv | 194 +++++++++++++++++++
 tb/tb_plat_collision_scan.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/plat_collision_scan_if.sv
// Bundle of the landing-scan request, layout buses and result signals
// exchanged between the physics FSM side and the collision scanner.
interface plat_collision_scan_if #(
    parameter int PLATFORM_NUM_PER_BLOCK = 7,
    parameter int PHY_WIDTH              = 16,
    parameter int BLOCK_LEN_WIDTH        = 4,
    parameter int VEL_WIDTH              = 8
);
    logic                                          start;
    logic                                          abort;
    logic        [PHY_WIDTH-1:0]                   char_x;
    logic signed [PHY_WIDTH:0]                     char_y;
    logic signed [VEL_WIDTH-1:0]                   char_vy;
    logic [PLATFORM_NUM_PER_BLOCK*PHY_WIDTH-1:0]       plat_relative_x;
    logic [PLATFORM_NUM_PER_BLOCK*PHY_WIDTH-1:0]       plat_relative_y;
    logic [PLATFORM_NUM_PER_BLOCK*BLOCK_LEN_WIDTH-1:0] plat_len;
    logic                                          busy;
    logic                                          done;
    logic                                          aborted;
    logic                                          hit;
    logic [2:0]                                    hit_idx;
    logic [PHY_WIDTH-1:0]                          land_y;
    logic [BLOCK_LEN_WIDTH-1:0]                    hit_len;

    modport master (
        output start, abort, char_x, char_y, char_vy,
               plat_relative_x, plat_relative_y, plat_len,
        input  busy, done, aborted, hit, hit_idx, land_y, hit_len
    );

    modport slave (
        input  start, abort, char_x, char_y, char_vy,
               plat_relative_x, plat_relative_y, plat_len,
        output busy, done, aborted, hit, hit_idx, land_y, hit_len
    );
endinterface

// File: rtl/plat_collision_scan.sv
// Sequential landing detector: snapshots the block layout on start, scans one
// platform per cycle and reports the highest platform top crossed this tick.
module plat_collision_scan #(
    parameter int PLATFORM_NUM_PER_BLOCK = 7,
    parameter int PHY_WIDTH              = 16,
    parameter int BLOCK_LEN_WIDTH        = 4,
    parameter int TILE_W                 = 8,
    parameter int CHAR_W                 = 16,
    parameter int VEL_WIDTH              = 8
) (
    input  logic                    sys_clk,
    input  logic                    sys_rst_n,
    plat_collision_scan_if.slave    bus
);
    localparam int N     = PLATFORM_NUM_PER_BLOCK;
    localparam int AW    = PHY_WIDTH + 2;
    localparam int IDX_W = 3;
    localparam logic signed [AW-1:0] TILE_W_S = AW'(TILE_W);
    localparam logic signed [AW-1:0] CHAR_W_S = AW'(CHAR_W);

    typedef enum logic [1:0] {IDLE, SCAN, REPORT} state_t;

    state_t state, state_nxt;
    logic   capture, advance, finish, cancel;

    logic        [N*PHY_WIDTH-1:0]       snap_x;
    logic        [N*PHY_WIDTH-1:0]       snap_y;
    logic        [N*BLOCK_LEN_WIDTH-1:0] snap_len;
    logic        [PHY_WIDTH-1:0]         snap_char_x;
    logic signed [PHY_WIDTH:0]           snap_char_y;
    logic signed [VEL_WIDTH-1:0]         snap_char_vy;

    logic [IDX_W-1:0]           idx;
    logic                       best_vld;
    logic [IDX_W-1:0]           best_idx;
    logic [PHY_WIDTH-1:0]       best_y;
    logic [BLOCK_LEN_WIDTH-1:0] best_len;

    logic                       busy_r, done_r, aborted_r, hit_r;
    logic [2:0]                 hit_idx_r;
    logic [PHY_WIDTH-1:0]       land_y_r;
    logic [BLOCK_LEN_WIDTH-1:0] hit_len_r;

    logic [PHY_WIDTH-1:0]       cur_px, cur_py;
    logic [BLOCK_LEN_WIDTH-1:0] cur_len;
    logic                       cur_hit;

    // Platform coordinates are unsigned and zero-extended; character y/vy are
    // sign-extended so a foot below the block origin still compares correctly.
    function automatic logic slot_hit(
        input logic        [PHY_WIDTH-1:0]       px,
        input logic        [PHY_WIDTH-1:0]       py,
        input logic        [BLOCK_LEN_WIDTH-1:0] len,
        input logic        [PHY_WIDTH-1:0]       cx,
        input logic signed [PHY_WIDTH:0]         cy,
        input logic signed [VEL_WIDTH-1:0]       vy
    );
        logic signed [AW-1:0] px_s, py_s, cx_s, cy_s, vy_s, len_s, w_s;
        px_s  = {2'b00, px};
        py_s  = {2'b00, py};
        cx_s  = {2'b00, cx};
        cy_s  = {cy[PHY_WIDTH], cy};
        vy_s  = {{(AW-VEL_WIDTH){vy[VEL_WIDTH-1]}}, vy};
        len_s = {{(AW-BLOCK_LEN_WIDTH){1'b0}}, len};
        w_s   = len_s * TILE_W_S;
        return (len != '0) &&
               (vy_s <= 0) &&
               (cy_s >= py_s) &&
               (cy_s + vy_s <= py_s) &&
               (cx_s + CHAR_W_S > px_s) &&
               (cx_s < px_s + w_s);
    endfunction

    assign cur_px  = snap_x[idx*PHY_WIDTH +: PHY_WIDTH];
    assign cur_py  = snap_y[idx*PHY_WIDTH +: PHY_WIDTH];
    assign cur_len = snap_len[idx*BLOCK_LEN_WIDTH +: BLOCK_LEN_WIDTH];
    assign cur_hit = slot_hit(cur_px, cur_py, cur_len, snap_char_x, snap_char_y, snap_char_vy);

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) state <= IDLE;
        else            state <= state_nxt;
    end

    // Abort outranks both scan progress and the REPORT completion.
    always_comb begin
        state_nxt = state;
        capture   = 1'b0;
        advance   = 1'b0;
        finish    = 1'b0;
        cancel    = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    capture   = 1'b1;
                    state_nxt = SCAN;
                end
            end
            SCAN: begin
                if (bus.abort) begin
                    cancel    = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    advance = 1'b1;
                    if (idx == IDX_W'(N-1)) state_nxt = REPORT;
                end
            end
            REPORT: begin
                if (bus.abort) cancel = 1'b1;
                else           finish = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            aborted_r <= 1'b0;
        end else begin
            done_r    <= finish;
            aborted_r <= cancel;
            if (capture)              busy_r <= 1'b1;
            else if (finish | cancel) busy_r <= 1'b0;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            snap_x       <= '0;
            snap_y       <= '0;
            snap_len     <= '0;
            snap_char_x  <= '0;
            snap_char_y  <= '0;
            snap_char_vy <= '0;
        end else if (capture) begin
            snap_x       <= bus.plat_relative_x;
            snap_y       <= bus.plat_relative_y;
            snap_len     <= bus.plat_len;
            snap_char_x  <= bus.char_x;
            snap_char_y  <= bus.char_y;
            snap_char_vy <= bus.char_vy;
        end
    end

    // Slots are visited in ascending order, so a strict compare keeps the
    // lower index on equal heights.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            idx      <= '0;
            best_vld <= 1'b0;
            best_idx <= '0;
            best_y   <= '0;
            best_len <= '0;
        end else if (capture) begin
            idx      <= '0;
            best_vld <= 1'b0;
            best_idx <= '0;
            best_y   <= '0;
            best_len <= '0;
        end else if (advance) begin
            idx <= idx + 1'b1;
            if (cur_hit && (!best_vld || cur_py > best_y)) begin
                best_vld <= 1'b1;
                best_idx <= idx;
                best_y   <= cur_py;
                best_len <= cur_len;
            end
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            hit_r     <= 1'b0;
            hit_idx_r <= '0;
            land_y_r  <= '0;
            hit_len_r <= '0;
        end else if (finish) begin
            hit_r     <= best_vld;
            hit_idx_r <= best_vld ? best_idx : '0;
            land_y_r  <= best_vld ? best_y   : '0;
            hit_len_r <= best_vld ? best_len : '0;
        end
    end

    assign bus.busy    = busy_r;
    assign bus.done    = done_r;
    assign bus.aborted = aborted_r;
    assign bus.hit     = hit_r;
    assign bus.hit_idx = hit_idx_r;
    assign bus.land_y  = land_y_r;
    assign bus.hit_len = hit_len_r;
endmodule

// File: tb/tb_plat_collision_scan.sv
// Directed bench for plat_collision_scan with hand-computed landing results.
module tb_plat_collision_scan;
    localparam int N  = 7;
    localparam int PW = 16;
    localparam int LW = 4;

    logic sys_clk   = 1'b0;
    logic sys_rst_n = 1'b1;
    int   n_total   = 0;
    int   n_bad     = 0;

    always #5 sys_clk = ~sys_clk;

    plat_collision_scan_if bus ();

    plat_collision_scan dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .bus       (bus)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic clear_layout();
        bus.plat_relative_x = '0;
        bus.plat_relative_y = '0;
        bus.plat_len        = '0;
    endtask

    task automatic set_slot(input int i, input int x, input int y, input int len);
        bus.plat_relative_x[i*PW +: PW] = PW'(x);
        bus.plat_relative_y[i*PW +: PW] = PW'(y);
        bus.plat_len[i*LW +: LW]        = LW'(len);
    endtask

    task automatic set_char(input int x, input int y, input int vy);
        bus.char_x  = PW'(x);
        bus.char_y  = (PW+1)'(y);
        bus.char_vy = 8'(vy);
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        do begin
            step();
            cyc++;
        end while (bus.done !== 1'b1 && cyc < 30);
    endtask

    task automatic count_pulses(input int cycles, output int n_done, output int n_abort);
        n_done  = 0;
        n_abort = 0;
        for (int k = 0; k < cycles; k++) begin
            step();
            if (bus.done === 1'b1)    n_done++;
            if (bus.aborted === 1'b1) n_abort++;
        end
    endtask

    task automatic do_scan(input string tag, input bit scramble,
                           input int eh, input int ei, input int ey, input int el);
        int cyc;
        step();
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        chk({tag, "_busy"}, bus.busy, 1);
        if (scramble) begin
            bus.plat_relative_x = '1;
            bus.plat_relative_y = '0;
            bus.plat_len        = '0;
            set_char(0, 0, 5);
        end
        wait_done(cyc);
        chk({tag, "_latency"}, cyc, 8);
        chk({tag, "_busy_low"}, bus.busy, 0);
        chk({tag, "_hit"}, bus.hit, eh);
        chk({tag, "_idx"}, bus.hit_idx, ei);
        chk({tag, "_land_y"}, bus.land_y, ey);
        chk({tag, "_len"}, bus.hit_len, el);
        step();
        chk({tag, "_done_pulse"}, bus.done, 0);
    endtask

    task automatic single_layout();
        clear_layout();
        set_slot(0, 250, 60, 10);
    endtask

    initial begin
        int cyc, nd, na;
        bus.start = 1'b0;
        bus.abort = 1'b0;
        clear_layout();
        set_char(0, 0, 0);

        #2 sys_rst_n = 1'b0;
        #1;
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_aborted", bus.aborted, 0);
        chk("rst_hit", bus.hit, 0);
        chk("rst_fields", {bus.hit_idx, bus.land_y, bus.hit_len}, 0);
        repeat (3) step();
        sys_rst_n = 1'b1;
        step();

        // Single landing and plain misses
        single_layout();
        set_char(260, 65, -8);
        do_scan("single", 0, 1, 0, 60, 10);
        set_char(260, 65, 5);
        do_scan("rising", 0, 0, 0, 0, 0);
        set_char(260, 68, -8);
        do_scan("cross_exact", 0, 1, 0, 60, 10);
        set_char(330, 65, -8);
        do_scan("touch_right", 0, 0, 0, 0, 0);
        set_char(329, 65, -8);
        do_scan("inside_right", 0, 1, 0, 60, 10);
        set_char(234, 65, -8);
        do_scan("touch_left", 0, 0, 0, 0, 0);
        set_char(235, 65, -8);
        do_scan("inside_left", 0, 1, 0, 60, 10);
        set_slot(0, 250, 60, 0);
        set_char(260, 65, -8);
        do_scan("disabled", 0, 0, 0, 0, 0);

        single_layout();
        set_char(260, 60, 0);
        do_scan("standing", 0, 1, 0, 60, 10);
        set_char(260, 61, 0);
        do_scan("hover", 0, 0, 0, 0, 0);

        // Multi-hit priority
        clear_layout();
        set_slot(2, 100, 80, 8);
        set_slot(5, 100, 70, 8);
        set_char(110, 85, -20);
        do_scan("multi_high", 0, 1, 2, 80, 8);
        set_slot(5, 100, 80, 8);
        do_scan("multi_equal", 0, 1, 2, 80, 8);
        set_slot(5, 100, 84, 3);
        do_scan("multi_later", 0, 1, 5, 84, 3);

        // Snapshot isolation
        single_layout();
        set_char(260, 65, -8);
        do_scan("snapshot", 1, 1, 0, 60, 10);

        // Abort mid-scan keeps the previous result
        single_layout();
        set_char(260, 65, 5);
        step();
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        repeat (3) step();
        bus.abort = 1'b1;
        step();
        bus.abort = 1'b0;
        chk("abort_pulse", bus.aborted, 1);
        chk("abort_no_done", bus.done, 0);
        chk("abort_busy", bus.busy, 0);
        chk("abort_hit_kept", bus.hit, 1);
        chk("abort_land_kept", bus.land_y, 60);
        step();
        chk("abort_pulse_end", bus.aborted, 0);
        count_pulses(12, nd, na);
        chk("abort_no_late_done", nd, 0);

        // Abort during REPORT wins over completion
        step();
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        repeat (7) step();
        bus.abort = 1'b1;
        step();
        bus.abort = 1'b0;
        chk("abort_rep_pulse", bus.aborted, 1);
        chk("abort_rep_no_done", bus.done, 0);
        chk("abort_rep_hit_kept", bus.hit, 1);

        // Abort together with start in IDLE: start accepted
        step();
        bus.start = 1'b1;
        bus.abort = 1'b1;
        step();
        bus.start = 1'b0;
        bus.abort = 1'b0;
        chk("idle_abort_busy", bus.busy, 1);
        chk("idle_abort_no_pulse", bus.aborted, 0);
        wait_done(cyc);
        chk("idle_abort_latency", cyc, 8);
        chk("idle_abort_hit", bus.hit, 0);

        // Start during busy is ignored
        set_char(260, 65, -8);
        step();
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        repeat (3) step();
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        count_pulses(25, nd, na);
        chk("busy_start_dones", nd, 1);
        chk("busy_start_hit", bus.hit, 1);

        // Start held high: one result every 9 cycles
        step();
        bus.start = 1'b1;
        wait_done(cyc);
        chk("b2b_first", cyc, 9);
        wait_done(cyc);
        chk("b2b_gap1", cyc, 9);
        wait_done(cyc);
        chk("b2b_gap2", cyc, 9);
        bus.start = 1'b0;
        chk("b2b_hit", bus.hit, 1);
        count_pulses(12, nd, na);
        chk("b2b_drain", nd, 0);
        chk("b2b_idle_busy", bus.busy, 0);

        // Asynchronous reset mid-scan
        step();
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        repeat (3) step();
        #1 sys_rst_n = 1'b0;
        #1;
        chk("arst_busy", bus.busy, 0);
        chk("arst_hit", bus.hit, 0);
        chk("arst_land_y", bus.land_y, 0);
        chk("arst_len", bus.hit_len, 0);
        chk("arst_flags", {bus.done, bus.aborted, bus.hit_idx}, 0);
        repeat (2) step();
        sys_rst_n = 1'b1;
        count_pulses(12, nd, na);
        chk("arst_no_done", nd, 0);
        chk("arst_no_abort", na, 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
